// File: rtl/gnrc_spram_arb_pkg.sv
// Shared types and helpers for the round-robin single-port RAM arbiter.
// Tags carry the widest supported requester index; users truncate to their own IW.
package gnrc_spram_arb_pkg;

   localparam int unsigned MaxIdW = 8;

   typedef struct packed {
      logic              vld;
      logic [MaxIdW-1:0] id;
   } arb_tag_t;

   // Successor of idx in a ring of n entries; valid for any n, not only powers of two.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/gnrc_rr_arbiter.sv
// Generic round-robin arbiter: the search starts at ptr, and ptr moves one past the
// winner whenever a grant is taken with advance high.
module gnrc_rr_arbiter
   import gnrc_spram_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW:0]   cand;
   logic          found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      ptr_d   = ptr_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         // ptr + i folded back into range without a modulo
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found             = 1'b1;
            gnt[cand[IW-1:0]] = 1'b1;
            gnt_idx           = cand[IW-1:0];
         end
      end
      if (advance && found) begin
         ptr_d = IW'(rr_next(32'(gnt_idx), NREQ));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/gnrc_spram.sv
// Behavioural single-port RAM, read-first, with DELAY cycles of read latency and
// optional byte-lane write enables.
module gnrc_spram #(
   parameter int unsigned DW           = 32,
   parameter int unsigned DP           = 512,
   parameter int unsigned DELAY        = 1,
   parameter int unsigned BYTE_WRITE   = 0,
   parameter int unsigned INIT_BY_ZERO = 1,
   parameter string       INIT_BY_FILE = "",
   parameter int unsigned AW           = $clog2(DP),
   parameter int unsigned MW           = (BYTE_WRITE != 0) ? (DW + 7) / 8 : 1
) (
   input  logic          clk,
   input  logic          en,
   input  logic [MW-1:0] we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [DP];
   logic [DW-1:0] pipe_q [DELAY];
   logic [DW-1:0] wmask;

   // Power-up contents come from the vendor macro's init attributes; only consistency is checked.
   if (INIT_BY_ZERO > 1 || (INIT_BY_ZERO != 0 && INIT_BY_FILE != "")) begin : g_bad_init
      $error("gnrc_spram: choose at most one init source");
   end

   if (BYTE_WRITE != 0) begin : g_byte_mask
      for (genvar i = 0; i < DW; i++) begin : g_bit
         assign wmask[i] = we[i / 8];
      end
   end else begin : g_word_mask
      assign wmask = {DW{we[0]}};
   end

   always_ff @(posedge clk) begin
      if (en) begin
         pipe_q[0] <= mem[addr];
         if (|we) begin
            mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
         end
      end
      for (int unsigned k = 1; k < DELAY; k++) begin
         pipe_q[k] <= pipe_q[k-1];
      end
   end

   assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/gnrc_spram_arb.sv
// Shares one single-port RAM between NREQ requesters with round-robin arbitration;
// read data is routed back to the issuer DELAY cycles after acceptance.
module gnrc_spram_arb
   import gnrc_spram_arb_pkg::*;
#(
   parameter int unsigned NREQ         = 2,
   parameter int unsigned DW           = 32,
   parameter int unsigned DP           = 512,
   parameter int unsigned DELAY        = 1,
   parameter int unsigned BYTE_WRITE   = 0,
   parameter int unsigned INIT_BY_ZERO = 1,
   parameter string       INIT_BY_FILE = "",
   parameter int unsigned AW           = $clog2(DP),
   parameter int unsigned MW           = (BYTE_WRITE != 0) ? (DW + 7) / 8 : 1,
   parameter int unsigned IW           = $clog2(NREQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NREQ-1:0]          req_valid_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic [NREQ-1:0][MW-1:0]  req_we_i,
   input  logic [NREQ-1:0][AW-1:0]  req_addr_i,
   input  logic [NREQ-1:0][DW-1:0]  req_wdata_i,
   output logic [NREQ-1:0]          rsp_valid_o,
   output logic [DW-1:0]            rsp_rdata_o
);

   if (NREQ < 2 || DELAY < 1 || IW > MaxIdW) begin : g_bad_cfg
      $error("gnrc_spram_arb: unsupported NREQ/DELAY configuration");
   end

   logic [NREQ-1:0] req_vld;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            ram_en;
   logic [MW-1:0]   ram_we;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_din;
   logic [DW-1:0]   ram_dout;
   arb_tag_t        tag_d;
   arb_tag_t        tag_q [DELAY];

   // Reset masks all requests so nothing is granted on the reset edge.
   assign req_vld = rst_i ? '0 : req_valid_i;

   gnrc_rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .clk     (clk_i),
      .rst     (rst_i),
      .req     (req_vld),
      .advance (1'b1),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready_o = gnt;

   always_comb begin
      ram_en    = |gnt;
      ram_we    = req_we_i[gnt_idx];
      ram_addr  = req_addr_i[gnt_idx];
      ram_din   = req_wdata_i[gnt_idx];
      tag_d.vld = ram_en && (ram_we == '0);
      tag_d.id  = MaxIdW'(gnt_idx);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < DELAY; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0] <= tag_d;
         for (int unsigned k = 1; k < DELAY; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   assign rsp_valid_o = tag_q[DELAY-1].vld ? (NREQ'(1) << tag_q[DELAY-1].id) : '0;
   assign rsp_rdata_o = ram_dout;

   gnrc_spram #(
      .DW           (DW),
      .DP           (DP),
      .DELAY        (DELAY),
      .BYTE_WRITE   (BYTE_WRITE),
      .INIT_BY_ZERO (INIT_BY_ZERO),
      .INIT_BY_FILE (INIT_BY_FILE),
      .AW           (AW),
      .MW           (MW)
   ) u_ram (
      .clk  (clk_i),
      .en   (ram_en),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

endmodule

// File: tb/tb_gnrc_spram_arb.sv
// Directed bench for gnrc_spram_arb (NREQ=3, DELAY=2, byte writes): a round-robin and
// memory model predicts grants and queues expected responses for in-order comparison.
module tb_gnrc_spram_arb;

   localparam int Nreq  = 3;
   localparam int Delay = 2;

   typedef struct {
      int          due;
      logic [2:0]  vec;
      logic [31:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      valid;
   logic [2:0]      ready;
   logic [2:0][3:0] we;
   logic [2:0][5:0] addr;
   logic [2:0][31:0] wdata;
   logic [2:0]      rsp_valid;
   logic [31:0]     rdata;

   int          cyc;
   int          mptr;
   int          nerr;
   int          nchk;
   int          gcount [3];
   logic [31:0] mem [64];
   exp_t        sbq [$];

   gnrc_spram_arb #(
      .NREQ         (3),
      .DW           (32),
      .DP           (64),
      .DELAY        (Delay),
      .BYTE_WRITE   (1),
      .INIT_BY_ZERO (1),
      .INIT_BY_FILE ("")
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (valid),
      .req_ready_o (ready),
      .req_we_i    (we),
      .req_addr_i  (addr),
      .req_wdata_i (wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rdata)
   );

   always #5 clk = ~clk;

   task automatic set_cmd(input int r, input logic [3:0] w, input logic [5:0] a,
                          input logic [31:0] d);
      we[r]    = w;
      addr[r]  = a;
      wdata[r] = d;
   endtask

   // One clock cycle: drive, check grant, update model, cross the edge, check response.
   task automatic step(input logic r, input logic [2:0] v);
      int         g;
      int         c;
      logic [2:0] expr;
      exp_t       e;
      rst   = r;
      valid = v;
      #1;
      g = -1;
      if (!r) begin
         for (int i = 0; i < Nreq; i++) begin
            c = (mptr + i) % Nreq;
            if (g < 0 && v[c]) g = c;
         end
      end
      expr = (g < 0) ? 3'b000 : 3'(1 << g);
      nchk++;
      assert (ready === expr) else begin
         nerr++;
         $error("FAIL grant cyc=%0d observed=%b expected=%b", cyc, ready, expr);
      end
      for (int i = 0; i < Nreq; i++) begin
         if (ready[i] === 1'b1) gcount[i]++;
      end
      if (g >= 0) begin
         if (we[g] == 4'b0000) begin
            e.due  = cyc + Delay;
            e.vec  = expr;
            e.data = mem[addr[g]];
            sbq.push_back(e);
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (we[g][b]) mem[addr[g]][8*b +: 8] = wdata[g][8*b +: 8];
            end
         end
         mptr = (g + 1) % Nreq;
      end
      if (r) begin
         mptr = 0;
         sbq.delete();
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         nchk++;
         assert (rsp_valid === e.vec) else begin
            nerr++;
            $error("FAIL rsp_valid cyc=%0d observed=%b expected=%b", cyc, rsp_valid, e.vec);
         end
         nchk++;
         assert (rdata === e.data) else begin
            nerr++;
            $error("FAIL rsp_rdata cyc=%0d observed=%h expected=%h", cyc, rdata, e.data);
         end
      end else begin
         nchk++;
         assert (rsp_valid === 3'b000) else begin
            nerr++;
            $error("FAIL rsp_idle cyc=%0d observed=%b expected=000", cyc, rsp_valid);
         end
      end
   endtask

   initial begin
      cyc   = 0;
      mptr  = 0;
      nerr  = 0;
      nchk  = 0;
      rst   = 1'b1;
      valid = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      for (int i = 0; i < Nreq; i++) gcount[i] = 0;

      // Reset with every requester valid: reset wins, nothing granted.
      step(1'b1, 3'b111);
      step(1'b1, 3'b111);

      // Single requester: write then read the same address next cycle.
      set_cmd(1, 4'hF, 6'h10, 32'hDEADBEEF);
      step(1'b0, 3'b010);
      set_cmd(1, 4'h0, 6'h10, 32'h0);
      step(1'b0, 3'b010);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);

      // Byte-lane write merges into the existing word.
      set_cmd(0, 4'hF, 6'h20, 32'h11223344);
      step(1'b0, 3'b001);
      set_cmd(0, 4'b0100, 6'h20, 32'h00AA0000);
      step(1'b0, 3'b001);
      set_cmd(0, 4'h0, 6'h20, 32'h0);
      step(1'b0, 3'b001);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);

      // Interleaved reads from two requesters route to the right issuer.
      set_cmd(0, 4'hF, 6'h01, 32'h0000000A);
      step(1'b0, 3'b001);
      set_cmd(1, 4'hF, 6'h02, 32'h0000000B);
      step(1'b0, 3'b010);
      set_cmd(0, 4'h0, 6'h01, 32'h0);
      step(1'b0, 3'b001);
      set_cmd(1, 4'h0, 6'h02, 32'h0);
      step(1'b0, 3'b010);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);

      // Fairness from reset: all valid for 9 cycles, reads from all three.
      step(1'b1, 3'b111);
      set_cmd(2, 4'h0, 6'h10, 32'h0);
      for (int i = 0; i < Nreq; i++) gcount[i] = 0;
      for (int i = 0; i < 9; i++) step(1'b0, 3'b111);
      for (int i = 0; i < Nreq; i++) begin
         nchk++;
         assert (gcount[i] == 3) else begin
            nerr++;
            $error("FAIL fair_count req=%0d observed=%0d expected=3", i, gcount[i]);
         end
      end

      // Non-power-of-two wrap: req2 alone, then all valid must grant 0.
      step(1'b0, 3'b100);
      step(1'b0, 3'b100);
      step(1'b0, 3'b111);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);

      // Reset mid-burst discards the read still in flight.
      step(1'b0, 3'b001);
      step(1'b0, 3'b010);
      step(1'b1, 3'b111);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);
      step(1'b0, 3'b111);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);
      step(1'b0, 3'b000);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
